wb_io_fifo: RTL and testbench

WB_IO_FIFO -- requirements
Module: wb_io_fifo

---
 rtl/wb_io_fifo.sv | 275 +++++++++++++++++++++++++++
 tb/tb_wb_io_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_io_fifo.sv
// ---------------------------------------------------------------------------
// wb_io_fifo
//   Wishbone-slave byte FIFO that paces bytes out to the IO pads. Software
//   pushes bytes through DATA; an output FSM pops one byte at a time, shows
//   it on io_out with a one-cycle io_strb_o, then waits DIV+1 further cycles
//   before the next byte may leave. The minimum byte period is DIV+2.
//
//   Register map (word offsets from BASE_ADDR, decoded on wbs_adr_i[31:4]):
//     0x0 DATA   W    push wbs_dat_i[7:0]
//     0x4 STATUS R/W1C [0] empty [1] full [2] ovf (W1C) [3] busy [15:8] count
//     0x8 CTRL   R/W  [0] en [1] flush (self-clearing, reads 0) [2] irq_en
//     0xC DIV    R/W  byte-period divider, DIV_W bits (DIV_W <= 32)
//   Any other address in the 16-byte window (misaligned offsets) is acked,
//   reads 0 and ignores writes.
//
//   Optional feature: define WB_IO_FIFO_IRQ_EN to build the registered level
//   interrupt irq_o = irq_en & ((empty & !busy) | ovf). Without the macro
//   irq_o is tied to 0 and CTRL[2] reads 0.
//
// Ports
//   wb_clk_i   in   1   sole clock
//   wb_rst_ni  in   1   asynchronous active-low reset
//   wbs_stb_i  in   1   Wishbone strobe
//   wbs_cyc_i  in   1   Wishbone cycle
//   wbs_we_i   in   1   Wishbone write enable
//   wbs_sel_i  in   4   byte lanes (ignored, all accesses are 32-bit)
//   wbs_adr_i  in   32  address
//   wbs_dat_i  in   32  write data
//   wbs_ack_o  out  1   acknowledge, one cycle after the request
//   wbs_dat_o  out  32  read data, 0 whenever wbs_ack_o is low
//   io_out     out  8   byte presented to the pads
//   io_strb_o  out  1   one-cycle strobe, io_out valid
//   io_oeb     out  9   active-low pad output enable (io_out + io_strb_o)
//   irq_o      out  1   level interrupt
// ---------------------------------------------------------------------------
module wb_io_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 8,
  parameter int          DIV_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  io_out,
  output logic        io_strb_o,
  output logic [8:0]  io_oeb,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  // Bus-side state
  logic              r_ack;
  logic [31:0]       r_dat;

  // Control / configuration registers
  logic              r_en;
  logic              r_ovf;
  logic [DIV_W-1:0]  r_div;

  // FIFO storage and bookkeeping
  logic [7:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  // Output FSM and datapath
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_cnt;
  logic [7:0]        r_io_out;
  logic              r_strb;

  logic              w_hit;
  logic              w_req;
  logic              w_aligned;
  logic              w_wr;
  logic              w_wr_data;
  logic              w_wr_status;
  logic              w_wr_ctrl;
  logic              w_wr_div;
  logic              w_flush;
  logic              w_empty;
  logic              w_full;
  logic              w_busy;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_ovf_set;
  logic              w_irq_en_rd;
  logic [31:0]       w_rdata;
  logic              w_unused;

  // Byte lanes are ignored; this reduction keeps them visibly consumed.
  assign w_unused = &{1'b0, wbs_sel_i, wbs_dat_i};

  // The r_ack term blocks a request in the ack cycle, so a held strobe
  // cannot produce back-to-back acks.
  assign w_hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_req     = w_hit & ~r_ack;
  assign w_aligned = (wbs_adr_i[1:0] == 2'b00);
  assign w_wr      = w_req & wbs_we_i & w_aligned;

  assign w_wr_data   = w_wr & (wbs_adr_i[3:2] == 2'd0);
  assign w_wr_status = w_wr & (wbs_adr_i[3:2] == 2'd1);
  assign w_wr_ctrl   = w_wr & (wbs_adr_i[3:2] == 2'd2);
  assign w_wr_div    = w_wr & (wbs_adr_i[3:2] == 2'd3);
  assign w_flush     = w_wr_ctrl & wbs_dat_i[1];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_busy  = (r_state == ST_WAIT);

  // A push at full is still taken when the FSM pops in the same cycle.
  // A flush wins over any push.
  assign w_push_ok = w_wr_data & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_wr_data & w_full & ~w_pop;

  // Read mux; misaligned offsets and DATA read as 0.
  always_comb begin
    w_rdata = '0;
    if (w_aligned) begin
      case (wbs_adr_i[3:2])
        2'd1:    w_rdata = {16'd0, 8'(r_count), 4'd0, w_busy, r_ovf, w_full, w_empty};
        2'd2:    w_rdata = {29'd0, w_irq_en_rd, 1'b0, r_en};
        2'd3:    w_rdata = 32'(r_div);
        default: w_rdata = '0;
      endcase
    end
  end

  // Ack and read data are both registered; r_dat is cleared on every
  // non-read cycle so wbs_dat_o is zero whenever ack is low.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~wbs_we_i) ? w_rdata : '0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  // CTRL.en, DIV and the sticky overflow flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_en  <= 1'b0;
      r_div <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_en <= wbs_dat_i[0];
      if (w_wr_div)  r_div <= wbs_dat_i[DIV_W-1:0];
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status & wbs_dat_i[2]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge wb_clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wbs_dat_i[7:0];
  end

  // Flush discards everything still queued; a byte already popped is in
  // r_io_out and keeps its period in the FSM.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output FSM next state; popping is only decided in IDLE, so clearing
  // en during WAIT lets the current period finish.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en & ~w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pop loads the byte, fires the strobe and reloads the period counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt    <= '0;
      r_io_out <= '0;
      r_strb   <= 1'b0;
    end else begin
      r_strb <= w_pop;
      if (w_pop) begin
        r_cnt    <= r_div;
        r_io_out <= r_mem[r_rd_ptr];
      end else if (w_busy && (r_cnt != '0)) begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

  assign io_out    = r_io_out;
  assign io_strb_o = r_strb;
  assign io_oeb    = r_en ? 9'h000 : 9'h1FF;

`ifdef WB_IO_FIFO_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // Interrupt fires when the FIFO has fully drained (including the byte in
  // flight) or when a byte was dropped.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= wbs_dat_i[2];
      r_irq <= r_irq_en & ((w_empty & ~w_busy) | r_ovf);
    end
  end

  assign w_irq_en_rd = r_irq_en;
  assign irq_o       = r_irq;
`else
  assign w_irq_en_rd = 1'b0;
  assign irq_o       = 1'b0;
`endif

endmodule

// File: tb/tb_wb_io_fifo.sv
// ---------------------------------------------------------------------------
// tb_wb_io_fifo
//   Self-checking bench for wb_io_fifo (default parameters). Register-level
//   behaviour is driven from a table of {access, expected read} records;
//   multi-cycle corner cases (pacing, pop/push at full, flush, interrupt,
//   asynchronous reset) are hand-written sequences with fixed cycle timing.
// ---------------------------------------------------------------------------
module tb_wb_io_fifo;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [3:0]  OFF_DATA   = 4'h0;
  localparam logic [3:0]  OFF_STATUS = 4'h4;
  localparam logic [3:0]  OFF_CTRL   = 4'h8;
  localparam logic [3:0]  OFF_DIV    = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dati;
  logic        ack;
  logic [31:0] dato;
  logic [7:0]  ioOut;
  logic        ioStrb;
  logic [8:0]  ioOeb;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  logic [7:0] strbData[$];
  int         strbCyc[$];

  typedef struct {
    bit          we;
    logic [3:0]  off;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  wb_io_fifo dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dati),
    .wbs_ack_o (ack),
    .wbs_dat_o (dato),
    .io_out    (ioOut),
    .io_strb_o (ioStrb),
    .io_oeb    (ioOeb),
    .irq_o     (irq)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Cycle counter used to time strobes and the interrupt edge.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Record every strobe with its byte and cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (ioStrb) begin
      strbData.push_back(ioOut);
      strbCyc.push_back(cycleCount);
    end
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One Wishbone access; requests from back-to-back calls are 2 cycles apart.
  task automatic busAccess(input bit w, input logic [3:0] off, input logic [31:0] d,
                           output logic [31:0] rd);
    @(negedge clk);
    stb  = 1'b1;
    cyc  = 1'b1;
    we   = w;
    sel  = 4'hF;
    adr  = BASE | {28'd0, off};
    dati = d;
    @(posedge clk);
    #1;
    checkOutput($sformatf("ack off 0x%0h", off), {31'd0, ack}, 32'd1);
    rd = dato;
    @(negedge clk);
    stb = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [31:0] rd);
    busAccess(v.we, v.off, v.wdat, rd);
  endtask

  task automatic writeReg(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] rd;
    busAccess(1'b1, off, d, rd);
  endtask

  task automatic readReg(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    busAccess(1'b0, off, 32'd0, rd);
    checkOutput(name, rd, exp);
  endtask

  task automatic waitStrobes(input int target, input int maxCyc);
    int n = 0;
    while (strbData.size() < target && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("strobe count", 32'(strbData.size()), 32'(target));
  endtask

  function automatic vec_t mkVec(input bit w, input logic [3:0] off,
                                 input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.we   = w;
    v.off  = off;
    v.wdat = d;
    v.exp  = e;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [31:0] irqBit;
    int base;
    int irqCyc;
    bit sawAck;

`ifdef WB_IO_FIFO_IRQ_EN
    irqBit = 32'h4;
`else
    irqBit = 32'h0;
`endif

    // Register-level vectors, all with en=0 so the FIFO never drains.
    vecs.push_back(mkVec(1'b1, OFF_DIV,    32'h0000_1234, 32'h0));
    vecs.push_back(mkVec(1'b0, OFF_DIV,    32'h0,         32'h0000_1234));
    vecs.push_back(mkVec(1'b1, OFF_DIV,    32'hFFFF_ABCD, 32'h0));
    vecs.push_back(mkVec(1'b0, OFF_DIV,    32'h0,         32'h0000_ABCD));
    vecs.push_back(mkVec(1'b1, OFF_CTRL,   32'h6,         32'h0));
    vecs.push_back(mkVec(1'b0, OFF_CTRL,   32'h0,         irqBit));
    vecs.push_back(mkVec(1'b1, OFF_CTRL,   32'h0,         32'h0));
    vecs.push_back(mkVec(1'b0, OFF_CTRL,   32'h0,         32'h0));
    vecs.push_back(mkVec(1'b0, OFF_DATA,   32'h0,         32'h0));
    vecs.push_back(mkVec(1'b1, 4'h9,       32'h55,        32'h0));
    vecs.push_back(mkVec(1'b0, OFF_DIV,    32'h0,         32'h0000_ABCD));
    vecs.push_back(mkVec(1'b0, 4'h5,       32'h0,         32'h0));
    for (int i = 1; i <= 9; i++) vecs.push_back(mkVec(1'b1, OFF_DATA, 32'(i), 32'h0));
    vecs.push_back(mkVec(1'b0, OFF_STATUS, 32'h0,         32'h0000_0806));
    vecs.push_back(mkVec(1'b1, OFF_STATUS, 32'h4,         32'h0));
    vecs.push_back(mkVec(1'b0, OFF_STATUS, 32'h0,         32'h0000_0802));
    vecs.push_back(mkVec(1'b1, OFF_CTRL,   32'h2,         32'h0));
    vecs.push_back(mkVec(1'b0, OFF_STATUS, 32'h0,         32'h0000_0001));
    vecs.push_back(mkVec(1'b0, OFF_CTRL,   32'h0,         32'h0));
    vecs.push_back(mkVec(1'b1, OFF_DIV,    32'h0,         32'h0));

    // Reset state, checked while reset is still asserted.
    rst_n = 1'b0;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dati = 32'h0;
    #12;
    checkOutput("reset io_out",   {24'd0, ioOut}, 32'h0);
    checkOutput("reset io_strb",  {31'd0, ioStrb}, 32'h0);
    checkOutput("reset io_oeb",   {23'd0, ioOeb}, 32'h1FF);
    checkOutput("reset ack",      {31'd0, ack}, 32'h0);
    checkOutput("reset dat_o",    dato, 32'h0);
    checkOutput("reset irq",      {31'd0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    readReg("reset STATUS", OFF_STATUS, 32'h0000_0001);
    readReg("reset CTRL",   OFF_CTRL,   32'h0);
    readReg("reset DIV",    OFF_DIV,    32'h0);

    $display("[TB] register table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], rd);
      if (!vecs[i].we) checkOutput($sformatf("vec%0d read", i), rd, vecs[i].exp);
    end

    // Outside the 16-byte window nothing answers.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10;
    sawAck = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ack) sawAck = 1'b1;
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    checkOutput("no ack outside window", {31'd0, sawAck}, 32'h0);

    $display("[TB] pacing A5/3C with DIV=3");
    writeReg(OFF_DATA, 32'hA5);
    writeReg(OFF_DATA, 32'h3C);
    writeReg(OFF_DIV,  32'h3);
    base = strbData.size();
    writeReg(OFF_CTRL, 32'h1);
    checkOutput("io_oeb enabled", {23'd0, ioOeb}, 32'h0);
    waitStrobes(base + 2, 60);
    if (strbData.size() >= base + 2) begin
      checkOutput("first byte",    {24'd0, strbData[base]},   32'hA5);
      checkOutput("second byte",   {24'd0, strbData[base+1]}, 32'h3C);
      checkOutput("byte period",   32'(strbCyc[base+1] - strbCyc[base]), 32'd5);
    end
    repeat (10) @(negedge clk);
    checkOutput("io_out holds last", {24'd0, ioOut}, 32'h3C);
    readReg("drained STATUS", OFF_STATUS, 32'h0000_0001);

    $display("[TB] push at full in pop cycle");
    writeReg(OFF_CTRL, 32'h0);
    writeReg(OFF_DIV,  32'd17);
    writeReg(OFF_DATA, 32'h11);
    base = strbData.size();
    // Requests land on relative cycles 0,2,4,...; the pop after the 17-long
    // period happens in cycle 20, exactly when the 9th byte is written.
    writeReg(OFF_CTRL, 32'h1);
    writeReg(OFF_DIV,  32'h0);
    for (int i = 0; i < 8; i++) writeReg(OFF_DATA, 32'hB0 + 32'(i));
    writeReg(OFF_DATA, 32'hE9);
    readReg("full pop+push STATUS", OFF_STATUS, 32'h0000_0802);
    waitStrobes(base + 10, 100);
    if (strbData.size() >= base + 10) begin
      checkOutput("pop+push first",  {24'd0, strbData[base]},   32'h11);
      checkOutput("pop+push eighth", {24'd0, strbData[base+8]}, 32'hB7);
      checkOutput("pop+push last",   {24'd0, strbData[base+9]}, 32'hE9);
    end
    writeReg(OFF_CTRL, 32'h0);

    $display("[TB] flush with byte in flight");
    writeReg(OFF_DIV, 32'h3);
    for (int i = 0; i < 5; i++) writeReg(OFF_DATA, 32'hC1 + 32'(i));
    base = strbData.size();
    writeReg(OFF_CTRL, 32'h1);
    writeReg(OFF_CTRL, 32'h3);
    readReg("flush STATUS busy", OFF_STATUS, 32'h0000_0009);
    repeat (20) @(negedge clk);
    checkOutput("flush strobes", 32'(strbData.size() - base), 32'd1);
    if (strbData.size() > base) checkOutput("flush inflight byte", {24'd0, strbData[base]}, 32'hC1);
    readReg("flush STATUS idle", OFF_STATUS, 32'h0000_0001);
    readReg("flush CTRL", OFF_CTRL, 32'h1);
    writeReg(OFF_CTRL, 32'h0);

    $display("[TB] interrupt on drain");
    writeReg(OFF_DIV,  32'h2);
    writeReg(OFF_DATA, 32'h77);
    base = strbData.size();
    writeReg(OFF_CTRL, 32'h5);
    irqCyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irq && irqCyc < 0) irqCyc = cycleCount;
    end
    waitStrobes(base + 1, 5);
`ifdef WB_IO_FIFO_IRQ_EN
    if (strbData.size() > base) checkOutput("irq delay", 32'(irqCyc - strbCyc[base]), 32'd4);
`else
    checkOutput("irq tied low", 32'(irqCyc), 32'hFFFF_FFFF);
`endif
    readReg("irq CTRL", OFF_CTRL, 32'h1 | irqBit);
    writeReg(OFF_CTRL, 32'h0);

    $display("[TB] asynchronous reset mid-period");
    writeReg(OFF_DIV,  32'd100);
    writeReg(OFF_DATA, 32'h5A);
    writeReg(OFF_DATA, 32'h5B);
    base = strbData.size();
    writeReg(OFF_CTRL, 32'h1);
    waitStrobes(base + 1, 10);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async io_out",  {24'd0, ioOut}, 32'h0);
    checkOutput("async io_strb", {31'd0, ioStrb}, 32'h0);
    checkOutput("async io_oeb",  {23'd0, ioOeb}, 32'h1FF);
    checkOutput("async ack",     {31'd0, ack}, 32'h0);
    checkOutput("async dat_o",   dato, 32'h0);
    checkOutput("async irq",     {31'd0, irq}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = strbData.size();
    repeat (20) @(negedge clk);
    checkOutput("no strobe after reset", 32'(strbData.size() - base), 32'd0);
    checkOutput("io_oeb after reset", {23'd0, ioOeb}, 32'h1FF);
    readReg("post-reset STATUS", OFF_STATUS, 32'h0000_0001);
    readReg("post-reset DIV",    OFF_DIV,    32'h0);
    readReg("post-reset CTRL",   OFF_CTRL,   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
